// File: rtl/sram_arbiter_wb8_vga_pkg.sv
// Shared widths and FSM state encoding for the SRAM arbiter.
package sram_arbiter_wb8_vga_pkg;

    localparam int ADR_W = 19;
    localparam int DAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_RD,
        ST_CPU_WR,
        ST_CPU_ACK
    } state_t;

endpackage

// File: rtl/sram_arbiter_wb8_vga.sv
// Arbiter for the external 512Kx8 async SRAM: VGA fetches take absolute priority with
// fixed one-cycle latency, and the 8-bit Wishbone CPU port uses the free slots.
module sram_arbiter_wb8_vga
    import sram_arbiter_wb8_vga_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vga_req,
    input  logic [ADR_W-1:0] vga_adr,
    output logic [DAT_W-1:0] vga_dat,
    input  logic [ADR_W-1:0] wb_adr,
    input  logic [DAT_W-1:0] wb_wdat,
    input  logic             wb_stb,
    input  logic             wb_we,
    output logic             wb_ack,
    output logic [DAT_W-1:0] wb_rdat,
    output logic [ADR_W-1:0] sram_adr,
    output logic [DAT_W-1:0] sram_wdat,
    output logic             sram_dat_oe,
    input  logic [DAT_W-1:0] sram_rdat,
    output logic             sram_we_n,
    output logic             sram_oe_n,
    output logic             sram_ce_n
);

    state_t state;

    // Video samples the pad data one edge after its request, so no register here.
    assign vga_dat = sram_rdat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wb_ack      <= 1'b0;
            wb_rdat     <= '0;
            sram_adr    <= '0;
            sram_wdat   <= '0;
            sram_dat_oe <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_ce_n   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wb_stb && !vga_req) begin
                        sram_adr <= wb_adr;
                        if (wb_we) begin
                            sram_wdat   <= wb_wdat;
                            sram_oe_n   <= 1'b1;
                            sram_dat_oe <= 1'b1;
                            sram_we_n   <= 1'b0;
                            state       <= ST_CPU_WR;
                        end else begin
                            sram_oe_n <= 1'b0;
                            state     <= ST_CPU_RD;
                        end
                    end
                end
                ST_CPU_RD: begin
                    // Captures the CPU byte before any same-edge VGA address switch lands.
                    wb_rdat <= sram_rdat;
                    wb_ack  <= 1'b1;
                    state   <= ST_CPU_ACK;
                end
                ST_CPU_WR: begin
                    sram_we_n   <= 1'b1;
                    sram_dat_oe <= 1'b0;
                    wb_ack      <= 1'b1;
                    state       <= ST_CPU_ACK;
                end
                ST_CPU_ACK: begin
                    // stb is still high here because the master only just saw the ack.
                    wb_ack <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // NOTE: non-blocking assignments, so this later VGA override wins over the
            // FSM's pad assignments on the same edge while the FSM state still advances.
            if (vga_req) begin
                sram_adr    <= vga_adr;
                sram_oe_n   <= 1'b0;
                sram_we_n   <= 1'b1;
                sram_dat_oe <= 1'b0;
            end
        end
    end

    // The video block never requests on two consecutive edges.
    vga_req_spacing: assert property (@(posedge clk) disable iff (!reset_n)
                                      vga_req |=> !vga_req);

endmodule

// File: tb/tb_sram_arbiter_wb8_vga.sv
// Bench for sram_arbiter_wb8_vga: async SRAM model, expected-memory scoreboard,
// per-cycle protocol monitor and directed CPU/VGA traffic.
module tb_sram_arbiter_wb8_vga;
    import sram_arbiter_wb8_vga_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             vga_req;
    logic [ADR_W-1:0] vga_adr;
    logic [DAT_W-1:0] vga_dat;
    logic [ADR_W-1:0] wb_adr;
    logic [DAT_W-1:0] wb_wdat;
    logic             wb_stb;
    logic             wb_we;
    logic             wb_ack;
    logic [DAT_W-1:0] wb_rdat;
    logic [ADR_W-1:0] sram_adr;
    logic [DAT_W-1:0] sram_wdat;
    logic             sram_dat_oe;
    logic [DAT_W-1:0] sram_rdat;
    logic             sram_we_n;
    logic             sram_oe_n;
    logic             sram_ce_n;

    always #5 clk = ~clk;

    sram_arbiter_wb8_vga dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vga_req     (vga_req),
        .vga_adr     (vga_adr),
        .vga_dat     (vga_dat),
        .wb_adr      (wb_adr),
        .wb_wdat     (wb_wdat),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_ack      (wb_ack),
        .wb_rdat     (wb_rdat),
        .sram_adr    (sram_adr),
        .sram_wdat   (sram_wdat),
        .sram_dat_oe (sram_dat_oe),
        .sram_rdat   (sram_rdat),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ce_n   (sram_ce_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Power-on contents of the SRAM: a cheap address hash.
    function automatic logic [7:0] pattern(input logic [ADR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
    endfunction

    logic [7:0] phys    [int];  // what the SRAM really holds
    logic [7:0] ref_mem [int];  // what the CPU has been told it holds
    int phys_ver    = 0;
    int phys_writes = 0;
    int exp_writes  = 0;
    int xfers       = 0;
    int acks        = 0;
    int cyc         = 0;
    bit mon_en      = 1'b0;

    function automatic logic [7:0] phys_lookup(input logic [ADR_W-1:0] a);
        return phys.exists(int'(a)) ? phys[int'(a)] : pattern(a);
    endfunction

    function automatic logic [7:0] ref_lookup(input logic [ADR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pattern(a);
    endfunction

    // Async SRAM: read path is combinational, the write commits while we_n is low.
    always @(sram_adr, sram_oe_n, sram_ce_n, sram_dat_oe, phys_ver)
        sram_rdat = (!sram_oe_n && !sram_ce_n && !sram_dat_oe) ? phys_lookup(sram_adr) : 8'h00;

    always @(negedge clk) begin
        if (sram_we_n === 1'b0 && sram_ce_n === 1'b0) begin
            phys[int'(sram_adr)] = sram_dat_oe ? sram_wdat : 8'hEE;
            phys_ver++;
            phys_writes++;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic             vga_q;
    logic [ADR_W-1:0] vga_adr_q;
    always @(posedge clk) begin
        vga_q     <= vga_req;
        vga_adr_q <= vga_adr;
    end

    // Per-cycle monitor: pad invariants and VGA data against the expected memory.
    bit prev_we_low = 1'b0;
    bit prev_ack    = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("dat_oe_implies_oe_n", 32'(!(sram_dat_oe && !sram_oe_n)), 32'd1);
            check("we_n_single_cycle", 32'(!(!sram_we_n && prev_we_low)), 32'd1);
            check("ack_single_cycle", 32'(!(wb_ack && prev_ack)), 32'd1);
            check("ce_n_low", 32'(sram_ce_n), 32'd0);
            if (wb_ack && !prev_ack) acks++;
            check("acks_le_xfers", 32'(acks <= xfers), 32'd1);
            if (vga_q) begin
                check("vga_sram_adr", 32'(sram_adr), 32'(vga_adr_q));
                check("vga_dat", 32'(vga_dat), 32'(ref_lookup(vga_adr_q)));
            end
            prev_we_low = !sram_we_n;
            prev_ack    = wb_ack;
        end
    end

    // Wishbone master, called at a negedge; holds stb through the edge that samples ack.
    task automatic wb_xfer(input logic we, input logic [ADR_W-1:0] adr, input logic [7:0] d,
                           output logic [7:0] rd, output int lat);
        wb_stb  = 1'b1;
        wb_we   = we;
        wb_adr  = adr;
        wb_wdat = d;
        xfers++;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!wb_ack && lat < 8);
        check("ack_seen", 32'(wb_ack), 32'd1);
        rd = wb_rdat;
        if (we) begin
            ref_mem[int'(adr)] = d;
            exp_writes++;
        end else begin
            check("wb_rdat", 32'(rd), 32'(ref_lookup(adr)));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // VGA traffic, called at a negedge: mode 1 graphics (every other edge), mode 2 text.
    task automatic vga_run(input int mode, input int n, input logic [ADR_W-1:0] base);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            logic r;
            if (mode == 1) r = (cyc % 2 == 0);
            else           r = ((cyc % 16) inside {9, 11, 13});
            vga_req = r;
            if (r) begin
                vga_adr = base + ADR_W'(k);
                k++;
            end
            @(negedge clk);
        end
        vga_req = 1'b0;
    endtask

    logic [7:0] rd;
    int         lat;

    initial begin
        reset_n = 1'b0;
        vga_req = 1'b0;
        vga_adr = '0;
        wb_adr  = '0;
        wb_wdat = '0;
        wb_stb  = 1'b0;
        wb_we   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_wb_rdat", 32'(wb_rdat), 32'd0);
        check("rst_sram_adr", 32'(sram_adr), 32'd0);
        check("rst_sram_wdat", 32'(sram_wdat), 32'd0);
        check("rst_dat_oe", 32'(sram_dat_oe), 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_ce_n", 32'(sram_ce_n), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Uncontended write then read back.
        wb_xfer(1'b1, 19'h12345, 8'hA5, rd, lat);
        check("wr_latency", 32'(lat), 32'd2);
        wb_xfer(1'b0, 19'h12345, 8'h00, rd, lat);
        check("rd_latency", 32'(lat), 32'd2);
        check("rd_value_a5", 32'(rd), 32'hA5);
        wb_stb = 1'b0;
        @(negedge clk);

        // Single VGA fetch, data pinned by hand.
        vga_req = 1'b1;
        vga_adr = 19'h20000;
        @(negedge clk);
        vga_req = 1'b0;
        check("vga_single_adr", 32'(sram_adr), 32'h20000);
        check("vga_single_dat", 32'(vga_dat), 32'h02);
        @(negedge clk);

        // Reset in the middle of a write.
        wb_stb  = 1'b1;
        wb_we   = 1'b1;
        wb_adr  = 19'h00777;
        wb_wdat = 8'h3C;
        @(negedge clk);
        check("midwr_we_n_low", 32'(sram_we_n), 32'd0);
        check("midwr_dat_oe_high", 32'(sram_dat_oe), 32'd1);
        ref_mem[32'h777] = 8'h3C;
        exp_writes++;
        reset_n = 1'b0;
        wb_stb  = 1'b0;
        @(negedge clk);
        check("midrst_we_n", 32'(sram_we_n), 32'd1);
        check("midrst_dat_oe", 32'(sram_dat_oe), 32'd0);
        check("midrst_ack", 32'(wb_ack), 32'd0);
        check("midrst_oe_n", 32'(sram_oe_n), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_no_late_ack", 32'(wb_ack), 32'd0);
        wb_xfer(1'b0, 19'h12345, 8'h00, rd, lat);
        check("post_rst_latency", 32'(lat), 32'd2);
        wb_stb = 1'b0;
        @(negedge clk);

        // Graphics-mode VGA every other edge with CPU reads in the gaps.
        fork
            vga_run(1, 60, 19'h20000);
            begin
                wb_xfer(1'b0, 19'h12345, 8'h00, rd, lat);
                check("gfx_rd0", 32'(rd), 32'hA5);
                check("gfx_lat0", 32'(lat >= 2 && lat <= 3), 32'd1);
                wb_xfer(1'b0, 19'h00100, 8'h00, rd, lat);
                check("gfx_lat1", 32'(lat >= 2 && lat <= 3), 32'd1);
                wb_xfer(1'b0, 19'h7FFFF, 8'h00, rd, lat);
                check("gfx_rd_top", 32'(rd), 32'h07);
                check("gfx_lat2", 32'(lat >= 2 && lat <= 3), 32'd1);
                wb_stb = 1'b0;
            end
        join
        @(negedge clk);

        // stb and vga_req on the same edge: VGA first, CPU one edge later.
        fork
            begin
                vga_req = 1'b1;
                vga_adr = 19'h20001;
                @(negedge clk);
                vga_req = 1'b0;
            end
            wb_xfer(1'b0, 19'h12345, 8'h00, rd, lat);
        join
        check("same_edge_latency", 32'(lat), 32'd3);
        check("same_edge_rd", 32'(rd), 32'hA5);
        wb_stb = 1'b0;
        @(negedge clk);

        // Text mode: fetches at col 9/11/13, CPU write starting on col 10.
        fork
            vga_run(2, 48, 19'h40000);
            begin
                do @(negedge clk); while (cyc % 16 != 10);
                wb_xfer(1'b1, 19'h30010, 8'h5A, rd, lat);
                check("text_wr_latency", 32'(lat), 32'd2);
                wb_stb = 1'b0;
            end
        join
        wb_xfer(1'b0, 19'h30010, 8'h00, rd, lat);
        check("text_wr_landed", 32'(rd), 32'h5A);
        wb_stb = 1'b0;
        @(negedge clk);

        // Back-to-back transfers with stb never dropped.
        for (int i = 0; i < 4; i++) begin
            wb_xfer(1'b1, 19'h00200 + ADR_W'(i), 8'h30 + 8'(i), rd, lat);
            check("b2b_wr_latency", 32'(lat), 32'd2);
        end
        for (int i = 0; i < 4; i++) begin
            wb_xfer(1'b0, 19'h00200 + ADR_W'(i), 8'h00, rd, lat);
            check("b2b_rd_latency", 32'(lat), 32'd2);
        end
        check("b2b_rd_last", 32'(rd), 32'h33);
        wb_stb = 1'b0;
        repeat (3) @(negedge clk);

        check("ack_count", 32'(acks), 32'(xfers));
        check("write_count", 32'(phys_writes), 32'(exp_writes));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
